// File: rtl/door_lock_ctrl.sv
// Door lock controller: consumes keypad correct/incorrect status levels and the
// door sensor, drives the strike, a lockout indicator and an intrusion alarm.
module door_lock_ctrl #(
  parameter int unsigned UNLOCK_CYCLES  = 500,
  parameter int unsigned LOCKOUT_CYCLES = 3000,
  parameter int unsigned MAX_FAILS      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       door_status_correct,
  input  logic       door_status_incorrect,
  input  logic       door_closed,
  output logic       lock_open,
  output logic       lockout,
  output logic       alarm,
  output logic [2:0] fail_count,
  output logic [1:0] state
);

  localparam int unsigned TW = 16;
  localparam int unsigned FW = 3;

  localparam logic [1:0] ST_LOCKED   = 2'd0;
  localparam logic [1:0] ST_UNLOCKED = 2'd1;
  localparam logic [1:0] ST_LOCKOUT  = 2'd2;
  localparam logic [1:0] ST_ALARM    = 2'd3;

  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LIMIT   = FW'(MAX_FAILS);

  logic          ok_q, ok_qq, bad_q, bad_qq;
  logic          primed;
  logic          ok_evt, bad_evt;
  logic [1:0]    state_q, state_nx;
  logic [TW-1:0] timer_q, timer_nx;
  logic [FW-1:0] fail_q, fail_nx, fail_inc;

  // Edge registers; the first cycle after reset loads both stages so a level
  // already high at reset release does not look like a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ok_q   <= 1'b0;
      ok_qq  <= 1'b0;
      bad_q  <= 1'b0;
      bad_qq <= 1'b0;
      primed <= 1'b0;
    end else if (!primed) begin
      ok_q   <= door_status_correct;
      ok_qq  <= door_status_correct;
      bad_q  <= door_status_incorrect;
      bad_qq <= door_status_incorrect;
      primed <= 1'b1;
    end else begin
      ok_q   <= door_status_correct;
      ok_qq  <= ok_q;
      bad_q  <= door_status_incorrect;
      bad_qq <= bad_q;
    end
  end

  assign ok_evt   = ok_q & ~ok_qq;
  assign bad_evt  = bad_q & ~bad_qq;
  assign fail_inc = fail_q + FW'(1);

  // State, timer, fail counter and decoded outputs, all updated together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOCKED;
      timer_q    <= '0;
      fail_q     <= '0;
      lock_open  <= 1'b0;
      lockout    <= 1'b0;
      alarm      <= 1'b0;
      fail_count <= '0;
      state      <= ST_LOCKED;
    end else begin
      state_q    <= state_nx;
      timer_q    <= timer_nx;
      fail_q     <= fail_nx;
      lock_open  <= (state_nx == ST_UNLOCKED);
      lockout    <= (state_nx == ST_LOCKOUT);
      alarm      <= (state_nx == ST_ALARM);
      fail_count <= fail_nx;
      state      <= state_nx;
    end
  end

  // Next-state logic; bad_evt has priority over ok_evt in LOCKED.
  always_comb begin
    state_nx = state_q;
    timer_nx = (timer_q != '0) ? timer_q - TW'(1) : '0;
    fail_nx  = fail_q;
    case (state_q)
      ST_LOCKED: begin
        if (bad_evt) begin
          if (fail_inc == FAIL_LIMIT) begin
            state_nx = ST_LOCKOUT;
            timer_nx = LOCKOUT_LOAD;
            fail_nx  = FAIL_LIMIT;
          end else begin
            fail_nx = fail_inc;
            if (!door_closed) begin
              state_nx = ST_ALARM;
              timer_nx = '0;
            end
          end
        end else if (ok_evt) begin
          state_nx = ST_UNLOCKED;
          timer_nx = UNLOCK_LOAD;
          fail_nx  = '0;
        end else if (!door_closed) begin
          state_nx = ST_ALARM;
          timer_nx = '0;
        end
      end
      ST_UNLOCKED: begin
        if (timer_q == '0) begin
          state_nx = door_closed ? ST_LOCKED : ST_ALARM;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_nx = ST_LOCKED;
          fail_nx  = '0;
        end
      end
      default: begin
        if (ok_evt && door_closed) begin
          state_nx = ST_LOCKED;
          fail_nx  = '0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Directed bench for door_lock_ctrl with short unlock/lockout windows.
module tb_door_lock_ctrl;

  logic       clk;
  logic       reset;
  logic       door_status_correct;
  logic       door_status_incorrect;
  logic       door_closed;
  logic       lock_open;
  logic       lockout;
  logic       alarm;
  logic [2:0] fail_count;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  int cnt;

  door_lock_ctrl #(
    .UNLOCK_CYCLES (8),
    .LOCKOUT_CYCLES(16),
    .MAX_FAILS     (3)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .door_status_correct  (door_status_correct),
    .door_status_incorrect(door_status_incorrect),
    .door_closed          (door_closed),
    .lock_open            (lock_open),
    .lockout              (lockout),
    .alarm                (alarm),
    .fail_count           (fail_count),
    .state                (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_ok();
    door_status_correct = 1'b1;
    tick(1);
    door_status_correct = 1'b0;
  endtask

  task automatic pulse_bad();
    door_status_incorrect = 1'b1;
    tick(1);
    door_status_incorrect = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 16'(state), 16'd0);
    check({tag, "_open"},  16'(lock_open), 16'd0);
    check({tag, "_lockout"}, 16'(lockout), 16'd0);
    check({tag, "_alarm"}, 16'(alarm), 16'd0);
    check({tag, "_fails"}, 16'(fail_count), 16'd0);
  endtask

  initial begin
    reset = 1'b0;
    door_status_correct = 1'b0;
    door_status_incorrect = 1'b0;
    door_closed = 1'b1;
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    tick(3);
    check_all_zero("idle");

    // Correct code: strike open for exactly 8 cycles
    pulse_ok();
    tick(1);
    check("unlock_state", 16'(state), 16'd1);
    cnt = 0;
    while (lock_open && cnt < 200) begin cnt++; tick(1); end
    check("unlock_len", 16'(cnt), 16'd8);
    check("relock_state", 16'(state), 16'd0);

    // Three wrong codes -> lockout for 16 cycles, correct code ignored
    pulse_bad(); tick(1);
    check("fail1", 16'(fail_count), 16'd1);
    pulse_bad(); tick(1);
    check("fail2", 16'(fail_count), 16'd2);
    pulse_bad(); tick(1);
    check("fail3", 16'(fail_count), 16'd3);
    check("lockout_state", 16'(state), 16'd2);
    cnt = 0;
    while (lockout && cnt < 200) begin
      door_status_correct = (cnt == 3);
      if (cnt == 10) begin
        check("lockout_hold_fail", 16'(fail_count), 16'd3);
        check("lockout_no_open", 16'(lock_open), 16'd0);
      end
      cnt++;
      tick(1);
    end
    door_status_correct = 1'b0;
    check("lockout_len", 16'(cnt), 16'd16);
    check("post_lockout_state", 16'(state), 16'd0);
    check("post_lockout_fails", 16'(fail_count), 16'd0);
    tick(2);
    check("post_lockout_idle", 16'(state), 16'd0);

    // Two wrong then correct clears the count
    pulse_bad(); tick(1);
    pulse_bad(); tick(1);
    check("two_fail", 16'(fail_count), 16'd2);
    pulse_ok(); tick(1);
    check("ok_clears_fails", 16'(fail_count), 16'd0);
    check("ok_unlocks", 16'(state), 16'd1);
    cnt = 0;
    while (lock_open && cnt < 200) begin cnt++; tick(1); end
    check("unlock_len2", 16'(cnt), 16'd8);

    // Intrusion while locked
    door_closed = 1'b0;
    tick(1);
    check("intrusion_alarm", 16'(alarm), 16'd1);
    check("intrusion_state", 16'(state), 16'd3);
    pulse_ok(); tick(1);
    check("alarm_open_ok", 16'(alarm), 16'd1);
    check("alarm_open_state", 16'(state), 16'd3);
    pulse_bad(); tick(1);
    check("alarm_ignores_bad", 16'(state), 16'd3);
    door_closed = 1'b1;
    pulse_ok(); tick(1);
    check("alarm_clear_state", 16'(state), 16'd0);
    check("alarm_clear_alarm", 16'(alarm), 16'd0);
    check("alarm_clear_fails", 16'(fail_count), 16'd0);

    // Door held open through unlock timeout
    pulse_ok(); tick(1);
    check("held_unlock", 16'(state), 16'd1);
    door_closed = 1'b0;
    cnt = 0;
    while (lock_open && cnt < 200) begin cnt++; tick(1); end
    check("held_len", 16'(cnt), 16'd8);
    check("held_state", 16'(state), 16'd3);
    check("held_alarm", 16'(alarm), 16'd1);
    door_closed = 1'b1;
    pulse_ok(); tick(1);
    check("held_recover", 16'(state), 16'd0);

    // Simultaneous correct/incorrect: incorrect wins
    door_status_correct = 1'b1;
    door_status_incorrect = 1'b1;
    tick(1);
    door_status_correct = 1'b0;
    door_status_incorrect = 1'b0;
    tick(1);
    check("both_fails", 16'(fail_count), 16'd1);
    check("both_state", 16'(state), 16'd0);
    check("both_open", 16'(lock_open), 16'd0);

    // Reset mid-lockout aborts immediately
    pulse_bad(); tick(1);
    pulse_bad(); tick(1);
    check("lockout2_state", 16'(state), 16'd2);
    tick(4);
    #2;
    reset = 1'b0;
    door_status_correct = 1'b1;
    #1;
    check_all_zero("midreset");
    tick(2);
    reset = 1'b1;
    tick(4);
    check("held_level_no_evt", 16'(state), 16'd0);
    check("held_level_no_open", 16'(lock_open), 16'd0);
    door_status_correct = 1'b0;
    tick(1);
    pulse_ok(); tick(1);
    check("after_reset_unlock", 16'(state), 16'd1);
    check("after_reset_fails", 16'(fail_count), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
